aes_ctr_iter_param: RTL and testbench

Parametrised iterative AES-CTR encrypt/decrypt core. It is the successor of the fixed AES-256 iterative CTR block and supports both AES-128 and AES-256. It adds three things:
- a configurable counter-increment width with wrap reporting;
- key retention across messages, so a new IV does not force a key reload;
- zeroing of output bytes that are not kept.

It sits between AXI-Stream producer/consumer shims and reuses the existing aes_key_expansion, aes_add_round_key and aes_round cells, one round per clock.

---
 rtl/aes_ctr_iter_param.sv | 355 +++++++++++++++++++++++++++++++++++
 tb/tb_aes_ctr_iter_param.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ctr_iter_param.sv
// Iterative AES-128/256 CTR core: one round per clock, key retained across messages,
// configurable counter-increment width with sticky wrap flag and zeroing of non-kept bytes.

package aes_ctr_iter_param_pkg;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // S-box built as the GF(2^8) inverse (a^254, which maps 0 to 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] inv;
    p   = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] byte_rev(input logic [127:0] x);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = x[127-8*i -: 8];
    return r;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

module aes_add_round_key (
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  output logic [127:0] state_out
);
  assign state_out = state_in ^ round_key;
endmodule

// Produces the next round key from the previous two; AES-128 feeds the same key to both inputs
module aes_key_expansion (
  input  logic [127:0] prev_key,
  input  logic [127:0] cur_key,
  input  logic         rot_word,
  input  logic [7:0]   rcon_byte,
  output logic [127:0] next_key
);
  import aes_ctr_iter_param_pkg::*;

  logic [31:0] last_word;
  logic [31:0] temp;

  always_comb begin
    last_word = rot_word ? {cur_key[103:96], cur_key[127:120], cur_key[119:112], cur_key[111:104]}
                         : cur_key[127:96];
    temp = {sbox(last_word[31:24]), sbox(last_word[23:16]), sbox(last_word[15:8]),
            sbox(last_word[7:0]) ^ (rot_word ? rcon_byte : 8'h00)};
    next_key = '0;
    next_key[31:0]   = prev_key[31:0]   ^ temp;
    next_key[63:32]  = prev_key[63:32]  ^ next_key[31:0];
    next_key[95:64]  = prev_key[95:64]  ^ next_key[63:32];
    next_key[127:96] = prev_key[127:96] ^ next_key[95:64];
  end
endmodule

// Byte i of a block lives in bits [8i+7:8i]; column c holds bytes 4c..4c+3
module aes_round (
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] state_out
);
  import aes_ctr_iter_param_pkg::*;

  logic [127:0] sb;
  logic [127:0] sr;
  logic [127:0] mc;
  logic [7:0]   a0, a1, a2, a3;

  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    a0 = 8'h00;
    a1 = 8'h00;
    a2 = 8'h00;
    a3 = 8'h00;
    for (int i = 0; i < 16; i++) sb[8*i +: 8] = sbox(state_in[8*i +: 8]);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[8*(4*c+r) +: 8] = sb[8*(4*((c+r)%4)+r) +: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr[8*(4*c)   +: 8];
      a1 = sr[8*(4*c+1) +: 8];
      a2 = sr[8*(4*c+2) +: 8];
      a3 = sr[8*(4*c+3) +: 8];
      mc[8*(4*c)   +: 8] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
      mc[8*(4*c+1) +: 8] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
      mc[8*(4*c+2) +: 8] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
      mc[8*(4*c+3) +: 8] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    end
    state_out = (final_round ? sr : mc) ^ round_key;
  end
endmodule

module aes_ctr_iter_param #(
  parameter int KEY_LENGTH = 256,
  parameter int CTR_WIDTH  = 128
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         S_axis_tvalid,
  output logic         S_axis_tready,
  input  logic [127:0] S_axis_tdata,
  input  logic [15:0]  S_axis_tkeep,
  input  logic         S_axis_tlast,
  input  logic         S_axis_tuser,
  output logic         M_axis_tvalid,
  input  logic         M_axis_tready,
  output logic [127:0] M_axis_tdata,
  output logic [15:0]  M_axis_tkeep,
  output logic         M_axis_tlast,
  output logic         Ctr_wrap
);
  import aes_ctr_iter_param_pkg::*;

  localparam int NR = (KEY_LENGTH == 128) ? 10 : 14;
  localparam int KB = KEY_LENGTH / 128;
  localparam logic [3:0]   NR_LAST  = 4'(NR);
  localparam logic [127:0] CTR_MASK = {128{1'b1}} >> (128 - CTR_WIDTH);

  localparam logic [2:0] ST_KEY         = 3'd0;
  localparam logic [2:0] ST_COUNTER     = 3'd1;
  localparam logic [2:0] ST_INPUT_TEXT  = 3'd2;
  localparam logic [2:0] ST_CIPHER      = 3'd3;
  localparam logic [2:0] ST_OUTPUT_TEXT = 3'd4;

  if (KEY_LENGTH != 128 && KEY_LENGTH != 256) begin : g_bad_key_length
    $error("aes_ctr_iter_param: KEY_LENGTH must be 128 or 256");
  end
  if (CTR_WIDTH != 32 && CTR_WIDTH != 64 && CTR_WIDTH != 96 && CTR_WIDTH != 128) begin : g_bad_ctr_width
    $error("aes_ctr_iter_param: CTR_WIDTH must be 32, 64, 96 or 128");
  end

  logic [2:0]   state;
  logic         key_beat;
  logic         key_valid;
  logic [255:0] key_reg;
  logic [127:0] ctr;
  logic         wrap;
  logic [127:0] text;
  logic [15:0]  text_keep;
  logic         text_last;
  logic [127:0] blk;
  logic [127:0] rk_a;
  logic [127:0] rk_b;
  logic [3:0]   round;
  logic         m_valid;
  logic [127:0] m_data;

  logic         s_hs;
  logic         m_hs;
  logic         last_key_beat;
  logic [127:0] ark_out;
  logic [127:0] round_in;
  logic [127:0] round_out;
  logic [127:0] keep_mask;
  logic [127:0] ctr_inc;
  logic         wrap_hit;
  logic [127:0] exp_prev;
  logic [127:0] exp_cur;
  logic         exp_rot;
  logic [7:0]   exp_rcon;
  logic [127:0] exp_out;
  logic [3:0]   next_round;

  assign S_axis_tready = !Rst && ((state == ST_KEY) ||
                         ((state == ST_COUNTER || state == ST_INPUT_TEXT) && key_valid));
  assign s_hs          = S_axis_tvalid && S_axis_tready;
  assign m_hs          = m_valid && M_axis_tready;
  assign last_key_beat = (KB == 1) ? 1'b1 : key_beat;
  assign next_round    = round + 4'd1;

  assign M_axis_tvalid = m_valid;
  assign M_axis_tdata  = m_data;
  assign M_axis_tkeep  = text_keep;
  assign M_axis_tlast  = text_last;
  assign Ctr_wrap      = wrap;

  // Only the low CTR_WIDTH bits count; the upper part of the IV is carried through untouched
  assign wrap_hit = (ctr & CTR_MASK) == CTR_MASK;
  assign ctr_inc  = (ctr & ~CTR_MASK) | ((ctr + 128'd1) & CTR_MASK);

  always_comb begin
    keep_mask = '0;
    for (int i = 0; i < 16; i++) keep_mask[8*i +: 8] = {8{text_keep[i]}};
  end

  // Round r needs rk_r in rk_b while it precomputes rk_(r+1); AES-256 alternates RotWord/Rcon
  always_comb begin
    exp_prev = rk_b;
    exp_cur  = rk_b;
    exp_rot  = 1'b1;
    exp_rcon = rcon(next_round);
    if (state == ST_INPUT_TEXT) begin
      exp_prev = key_reg[127:0];
      exp_cur  = key_reg[127:0];
      exp_rcon = rcon(4'd1);
    end else if (KB == 2) begin
      exp_prev = rk_a;
      exp_rot  = round[0];
      exp_rcon = rcon(next_round >> 1);
    end
  end

  aes_key_expansion u_key_expansion (
    .prev_key  (exp_prev),
    .cur_key   (exp_cur),
    .rot_word  (exp_rot),
    .rcon_byte (exp_rcon),
    .next_key  (exp_out)
  );

  aes_add_round_key u_add_round_key (
    .state_in  (blk),
    .round_key (rk_a),
    .state_out (ark_out)
  );

  assign round_in = (round == 4'd1) ? ark_out : blk;

  aes_round u_round (
    .state_in    (round_in),
    .round_key   (rk_b),
    .final_round (round == NR_LAST),
    .state_out   (round_out)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= ST_KEY;
      key_beat  <= 1'b0;
      key_valid <= 1'b0;
      key_reg   <= '0;
      ctr       <= '0;
      wrap      <= 1'b0;
      text      <= '0;
      text_keep <= '0;
      text_last <= 1'b0;
      blk       <= '0;
      rk_a      <= '0;
      rk_b      <= '0;
      round     <= 4'd1;
      m_valid   <= 1'b0;
      m_data    <= '0;
    end else begin
      case (state)
        ST_KEY: begin
          if (s_hs) begin
            if (key_beat) key_reg[255:128] <= S_axis_tdata;
            else          key_reg[127:0]   <= S_axis_tdata;
            if (last_key_beat) begin
              key_beat  <= 1'b0;
              key_valid <= 1'b1;
              state     <= ST_COUNTER;
            end else begin
              key_beat <= 1'b1;
            end
          end
        end
        ST_COUNTER: begin
          if (s_hs) begin
            if (S_axis_tuser) begin
              key_reg[127:0] <= S_axis_tdata;
              if (KB == 2) begin
                key_valid <= 1'b0;
                key_beat  <= 1'b1;
                state     <= ST_KEY;
              end
            end else begin
              ctr   <= byte_rev(S_axis_tdata);
              wrap  <= 1'b0;
              state <= ST_INPUT_TEXT;
            end
          end
        end
        ST_INPUT_TEXT: begin
          if (s_hs) begin
            text      <= S_axis_tdata;
            text_keep <= S_axis_tkeep;
            text_last <= S_axis_tlast;
            blk       <= byte_rev(ctr);
            rk_a      <= key_reg[127:0];
            rk_b      <= (KB == 2) ? key_reg[255:128] : exp_out;
            round     <= 4'd1;
            state     <= ST_CIPHER;
          end
        end
        ST_CIPHER: begin
          blk   <= round_out;
          rk_a  <= rk_b;
          rk_b  <= exp_out;
          round <= next_round;
          if (round == NR_LAST) begin
            m_data  <= (text ^ round_out) & keep_mask;
            m_valid <= 1'b1;
            round   <= 4'd1;
            state   <= ST_OUTPUT_TEXT;
          end
        end
        ST_OUTPUT_TEXT: begin
          if (m_hs) begin
            m_valid <= 1'b0;
            ctr     <= ctr_inc;
            if (wrap_hit) wrap <= 1'b1;
            state <= text_last ? ST_COUNTER : ST_INPUT_TEXT;
          end
        end
        default: state <= ST_KEY;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_ctr_iter_param.sv
// Directed-vector bench for aes_ctr_iter_param: three instances cover AES-128, AES-256 and a
// 32-bit counter field; vectors come from the published CTR and zero-key AES examples.

module tb_aes_ctr_iter_param;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  logic         s_tvalid [3];
  logic         s_tready [3];
  logic [127:0] s_tdata  [3];
  logic [15:0]  s_tkeep  [3];
  logic         s_tlast  [3];
  logic         s_tuser  [3];
  logic         m_tvalid [3];
  logic         m_tready [3];
  logic [127:0] m_tdata  [3];
  logic [15:0]  m_tkeep  [3];
  logic         m_tlast  [3];
  logic         m_wrap   [3];

  int checks = 0;
  int errors = 0;

  aes_ctr_iter_param #(.KEY_LENGTH(128), .CTR_WIDTH(128)) dut128 (
    .Clk(Clk), .Rst(Rst),
    .S_axis_tvalid(s_tvalid[0]), .S_axis_tready(s_tready[0]), .S_axis_tdata(s_tdata[0]),
    .S_axis_tkeep(s_tkeep[0]), .S_axis_tlast(s_tlast[0]), .S_axis_tuser(s_tuser[0]),
    .M_axis_tvalid(m_tvalid[0]), .M_axis_tready(m_tready[0]), .M_axis_tdata(m_tdata[0]),
    .M_axis_tkeep(m_tkeep[0]), .M_axis_tlast(m_tlast[0]), .Ctr_wrap(m_wrap[0])
  );

  aes_ctr_iter_param #(.KEY_LENGTH(256), .CTR_WIDTH(128)) dut256 (
    .Clk(Clk), .Rst(Rst),
    .S_axis_tvalid(s_tvalid[1]), .S_axis_tready(s_tready[1]), .S_axis_tdata(s_tdata[1]),
    .S_axis_tkeep(s_tkeep[1]), .S_axis_tlast(s_tlast[1]), .S_axis_tuser(s_tuser[1]),
    .M_axis_tvalid(m_tvalid[1]), .M_axis_tready(m_tready[1]), .M_axis_tdata(m_tdata[1]),
    .M_axis_tkeep(m_tkeep[1]), .M_axis_tlast(m_tlast[1]), .Ctr_wrap(m_wrap[1])
  );

  aes_ctr_iter_param #(.KEY_LENGTH(128), .CTR_WIDTH(32)) dut32 (
    .Clk(Clk), .Rst(Rst),
    .S_axis_tvalid(s_tvalid[2]), .S_axis_tready(s_tready[2]), .S_axis_tdata(s_tdata[2]),
    .S_axis_tkeep(s_tkeep[2]), .S_axis_tlast(s_tlast[2]), .S_axis_tuser(s_tuser[2]),
    .M_axis_tvalid(m_tvalid[2]), .M_axis_tready(m_tready[2]), .M_axis_tdata(m_tdata[2]),
    .M_axis_tkeep(m_tkeep[2]), .M_axis_tlast(m_tlast[2]), .Ctr_wrap(m_wrap[2])
  );

  // Vectors are written byte 0 first; the bus carries byte 0 in [7:0]
  function automatic logic [127:0] br(input logic [127:0] x);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = x[127-8*i -: 8];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Drives one input beat and returns 1 time unit after the handshake edge
  task automatic applyStimulus(input int d, input logic [127:0] data, input logic [15:0] keep,
                               input logic last, input logic user);
    int n;
    n = 0;
    s_tdata[d]  = data;
    s_tkeep[d]  = keep;
    s_tlast[d]  = last;
    s_tuser[d]  = user;
    s_tvalid[d] = 1'b1;
    while (!s_tready[d] && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (!s_tready[d]) begin
      checkOutput("accept_timeout", 128'd0, 128'd1);
    end else begin
      @(posedge Clk);
    end
    #1;
    s_tvalid[d] = 1'b0;
  endtask

  // Latency is counted in clocks with the handshake edge as clock 1
  task automatic collectBeat(input int d, input string tag, input logic [127:0] exp,
                             input logic chk, input int lat, output logic [127:0] got,
                             output logic [15:0] got_keep, output logic got_last);
    int n;
    n = 1;
    got = '0;
    got_keep = '0;
    got_last = 1'b0;
    while (!m_tvalid[d] && n < 200) begin
      @(posedge Clk);
      #1;
      n++;
    end
    if (lat > 0) checkOutput({tag, "_latency"}, 128'(n), 128'(lat));
    if (!m_tvalid[d]) begin
      checkOutput({tag, "_valid_timeout"}, 128'd0, 128'd1);
    end else begin
      got      = m_tdata[d];
      got_keep = m_tkeep[d];
      got_last = m_tlast[d];
      if (chk) checkOutput(tag, got, exp);
      m_tready[d] = 1'b1;
      @(posedge Clk);
      #1;
      m_tready[d] = 1'b0;
    end
  endtask

  logic [127:0] k128, iv, pt1, pt2, ct1, ct2, ct256, zero_ct, iv32a, iv32b, got;
  logic [255:0] k256;
  logic [15:0]  got_keep;
  logic         got_last;
  logic         bad;
  logic         seen;

  initial begin
    k128    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    k256    = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    iv      = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    pt1     = 128'h6bc1bee22e409f96e93d7e117393172a;
    pt2     = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    ct1     = 128'h874d6191b620e3261bef6864990db6ce;
    ct2     = 128'h9806f66b7970fdff8617187bb9fffdff;
    ct256   = 128'h601ec313775789a5b7a7f504bbf3d228;
    zero_ct = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    iv32a   = 128'h000000000000000000000000ffffffff;
    iv32b   = 128'h00112233445566778899aabbffffffff;
    for (int i = 0; i < 3; i++) begin
      s_tvalid[i] = 1'b0;
      s_tdata[i]  = '0;
      s_tkeep[i]  = '0;
      s_tlast[i]  = 1'b0;
      s_tuser[i]  = 1'b0;
      m_tready[i] = 1'b0;
    end

    Rst = 1'b1;
    #1;
    checkOutput("reset_s_tready", 128'(s_tready[0]), 128'd0);
    checkOutput("reset_m_tvalid", 128'(m_tvalid[0]), 128'd0);
    checkOutput("reset_m_tdata", m_tdata[0], 128'd0);
    checkOutput("reset_wrap", 128'(m_wrap[0]), 128'd0);
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    #1;
    checkOutput("after_reset_ready_key", 128'(s_tready[0]), 128'd1);

    $display("[TB] AES-128 two-block message");
    applyStimulus(0, br(k128), 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(0, br(iv), 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(0, br(pt1), 16'hFFFF, 1'b0, 1'b0);
    collectBeat(0, "aes128_blk1", br(ct1), 1'b1, 11, got, got_keep, got_last);
    checkOutput("aes128_blk1_tlast", 128'(got_last), 128'd0);
    applyStimulus(0, br(pt2), 16'hFFFF, 1'b1, 1'b0);
    collectBeat(0, "aes128_blk2", br(ct2), 1'b1, 11, got, got_keep, got_last);
    checkOutput("aes128_blk2_tlast", 128'(got_last), 128'd1);
    checkOutput("aes128_blk2_tkeep", 128'(got_keep), 128'hFFFF);
    checkOutput("aes128_no_wrap", 128'(m_wrap[0]), 128'd0);

    $display("[TB] key retention");
    applyStimulus(0, br(iv), 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(0, br(pt1), 16'hFFFF, 1'b1, 1'b0);
    collectBeat(0, "retain_blk1", br(ct1), 1'b1, 11, got, got_keep, got_last);

    $display("[TB] partial block");
    applyStimulus(0, br(iv), 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(0, br(pt1), 16'h00FF, 1'b1, 1'b0);
    collectBeat(0, "partial_data", br(128'h874d6191b620e3260000000000000000), 1'b1, 0,
                got, got_keep, got_last);
    checkOutput("partial_tkeep", 128'(got_keep), 128'h00FF);
    checkOutput("partial_tlast", 128'(got_last), 128'd1);

    $display("[TB] output stall");
    applyStimulus(0, br(iv), 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(0, br(pt1), 16'hFFFF, 1'b0, 1'b0);
    for (int i = 0; i < 40 && !m_tvalid[0]; i++) begin
      @(posedge Clk);
      #1;
    end
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk);
      #1;
      if (!m_tvalid[0] || m_tdata[0] !== br(ct1) || s_tready[0]) bad = 1'b1;
    end
    checkOutput("stall_hold", 128'(bad), 128'd0);
    collectBeat(0, "stall_blk1", br(ct1), 1'b1, 0, got, got_keep, got_last);
    applyStimulus(0, br(pt2), 16'hFFFF, 1'b1, 1'b0);
    collectBeat(0, "stall_blk2", br(ct2), 1'b1, 11, got, got_keep, got_last);

    $display("[TB] rekey with zero key");
    applyStimulus(0, 128'd0, 16'hFFFF, 1'b0, 1'b1);
    applyStimulus(0, br(iv), 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(0, br(pt1), 16'hFFFF, 1'b1, 1'b0);
    collectBeat(0, "rekey_blk", 128'd0, 1'b0, 11, got, got_keep, got_last);
    checkOutput("rekey_differs", 128'(got != br(ct1)), 128'd1);
    applyStimulus(0, 128'd0, 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(0, 128'd0, 16'hFFFF, 1'b1, 1'b0);
    collectBeat(0, "zero_key_zero_ctr", br(zero_ct), 1'b1, 11, got, got_keep, got_last);

    $display("[TB] AES-256 block");
    applyStimulus(1, br(k256[255:128]), 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(1, br(k256[127:0]), 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(1, br(iv), 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(1, br(pt1), 16'hFFFF, 1'b1, 1'b0);
    collectBeat(1, "aes256_blk1", br(ct256), 1'b1, 15, got, got_keep, got_last);

    $display("[TB] 32-bit counter wrap");
    applyStimulus(2, 128'd0, 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(2, br(iv32a), 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(2, 128'd0, 16'hFFFF, 1'b0, 1'b0);
    checkOutput("wrap_before", 128'(m_wrap[2]), 128'd0);
    collectBeat(2, "ctr32_blk1", 128'd0, 1'b0, 11, got, got_keep, got_last);
    checkOutput("wrap_after_first", 128'(m_wrap[2]), 128'd1);
    applyStimulus(2, 128'd0, 16'hFFFF, 1'b1, 1'b0);
    collectBeat(2, "ctr32_blk2_wrapped", br(zero_ct), 1'b1, 11, got, got_keep, got_last);
    checkOutput("wrap_sticky_end", 128'(m_wrap[2]), 128'd1);
    applyStimulus(2, br(iv32b), 16'hFFFF, 1'b0, 1'b0);
    checkOutput("wrap_cleared_by_iv", 128'(m_wrap[2]), 128'd0);
    applyStimulus(2, 128'd0, 16'hFFFF, 1'b1, 1'b0);
    collectBeat(2, "ctr32_iv_b", 128'd0, 1'b0, 11, got, got_keep, got_last);
    checkOutput("wrap_iv_b", 128'(m_wrap[2]), 128'd1);

    $display("[TB] reset during cipher");
    applyStimulus(0, br(iv), 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(0, br(pt1), 16'hFFFF, 1'b1, 1'b0);
    repeat (3) begin
      @(posedge Clk);
      #1;
    end
    Rst = 1'b1;
    #1;
    checkOutput("midrst_s_tready", 128'(s_tready[0]), 128'd0);
    checkOutput("midrst_m_tvalid", 128'(m_tvalid[0]), 128'd0);
    checkOutput("midrst_m_tdata", m_tdata[0], 128'd0);
    checkOutput("midrst_m_tkeep", 128'(m_tkeep[0]), 128'd0);
    checkOutput("midrst_m_tlast", 128'(m_tlast[0]), 128'd0);
    checkOutput("midrst_wrap32", 128'(m_wrap[2]), 128'd0);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    checkOutput("midrst_ready_key", 128'(s_tready[0]), 128'd1);
    applyStimulus(0, br(pt1), 16'hFFFF, 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge Clk);
      #1;
      if (m_tvalid[0]) seen = 1'b1;
    end
    checkOutput("no_text_after_reset", 128'(seen), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
